// File: rtl/apb_pkg.sv
// Shared APB types and sizes for the register-file completer and its bus interface.
// Bus widths live here so the interface and the design always agree.
package apb_pkg;

    localparam int PADDR_SIZE = 4;
    localparam int PDATA_SIZE = 8;
    localparam int PSTRB_SIZE = PDATA_SIZE / 8;
    localparam int CNT_W      = 4;

    typedef logic [PADDR_SIZE-1:0] apb_addr_t;
    typedef logic [PDATA_SIZE-1:0] apb_data_t;
    typedef logic [PSTRB_SIZE-1:0] apb_strb_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } apb_state_e;

    // Request fields captured at the setup phase
    typedef struct packed {
        apb_addr_t addr;
        logic      write;
        apb_data_t wdata;
        apb_strb_t strb;
    } apb_req_t;

endpackage

// File: rtl/device_if.sv
// APB bus bundle between a requester (master) and the register-file completer (slave).
interface device_if;
    import apb_pkg::*;

    logic      PSEL;
    logic      PENABLE;
    apb_addr_t PADDR;
    apb_strb_t PSTRB;
    apb_data_t PWDATA;
    logic      PWRITE;
    apb_data_t PRDATA;
    logic      PREADY;
    logic      PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PSTRB, PWDATA, PWRITE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PSTRB, PWDATA, PWRITE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_slave_fsm.sv
// Transfer sequencer: latches the setup-phase request, counts wait states, drives PREADY
// and emits a one-cycle commit pulse together with the latched request.
module apb_slave_fsm
    import apb_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic      PCLK,
    input  logic      PRESETn,
    input  logic      psel_i,
    input  logic      penable_i,
    input  apb_req_t  bus_req_i,
    output logic      pready_o,
    output logic      resp_set_o,
    output apb_addr_t resp_addr_o,
    output logic      resp_write_o,
    output logic      commit_o,
    output apb_req_t  commit_req_o
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam bit               NO_WAIT  = (WAIT_STATES == 0);

    apb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    apb_req_t         req_q;
    logic             pready_q;

    logic setup_seen;
    logic wait_done;

    assign setup_seen = (state_q == IDLE) && psel_i && !penable_i;
    assign wait_done  = (state_q == WAIT) && psel_i && (cnt_q == CNT_LAST);

    // The response is loaded on the same edge that raises PREADY
    assign resp_set_o = PRESETn && ((setup_seen && NO_WAIT) || wait_done);
    assign commit_o   = PRESETn && (state_q == ACCESS) && psel_i && penable_i && pready_q;

    // With zero wait states the response edge is the setup edge, so use the live fields
    assign resp_addr_o  = (state_q == IDLE) ? bus_req_i.addr  : req_q.addr;
    assign resp_write_o = (state_q == IDLE) ? bus_req_i.write : req_q.write;

    assign commit_req_o = req_q;
    assign pready_o     = pready_q;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            pready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only; the default below is overridden by later
            // assignments in the same edge, and every read sees the pre-edge value.
            pready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (setup_seen) begin
                        req_q <= bus_req_i;
                        cnt_q <= WAIT_CNT;
                        if (NO_WAIT) begin
                            pready_q <= 1'b1;
                            state_q  <= ACCESS;
                        end else begin
                            state_q  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!psel_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_LAST;
                        if (wait_done) begin
                            pready_q <= 1'b1;
                            state_q  <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Completion or abort: PREADY is high for exactly this one cycle
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer holding NUM_REGS byte-lane-writable registers with configurable wait states,
// out-of-range error response and a flat export of all register contents.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS    = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    device_if.slave                        bus,
    output logic [NUM_REGS*PDATA_SIZE-1:0] reg_q
);

    apb_req_t  bus_req;
    apb_req_t  commit_req;
    apb_addr_t resp_addr;
    logic      resp_write;
    logic      resp_set;
    logic      commit;
    logic      pready;

    logic [NUM_REGS-1:0][PDATA_SIZE-1:0] regs_q;
    logic [NUM_REGS-1:0][PDATA_SIZE-1:0] regs_d;
    apb_data_t rd_data;
    apb_data_t prdata_q;
    apb_data_t prdata_d;
    logic      pslverr_q;
    logic      pslverr_d;

    // Full-width compare: addresses at or above NUM_REGS never alias onto a register
    function automatic logic in_range(input apb_addr_t addr);
        return 32'(addr) < 32'(NUM_REGS);
    endfunction

    assign bus_req = '{addr: bus.PADDR, write: bus.PWRITE, wdata: bus.PWDATA, strb: bus.PSTRB};

    apb_slave_fsm #(
        .WAIT_STATES(WAIT_STATES)
    ) u_fsm (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .psel_i       (bus.PSEL),
        .penable_i    (bus.PENABLE),
        .bus_req_i    (bus_req),
        .pready_o     (pready),
        .resp_set_o   (resp_set),
        .resp_addr_o  (resp_addr),
        .resp_write_o (resp_write),
        .commit_o     (commit),
        .commit_req_o (commit_req)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (resp_addr == PADDR_SIZE'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    // Response is non-zero only on the edge that raises PREADY, so it clears with PREADY
    always_comb begin
        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (resp_set) begin
            if (!in_range(resp_addr)) begin
                pslverr_d = 1'b1;
            end else if (!resp_write) begin
                prdata_d = rd_data;
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (commit && commit_req.write && in_range(commit_req.addr)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_req.addr == PADDR_SIZE'(i)) begin
                    for (int b = 0; b < PSTRB_SIZE; b++) begin
                        if (commit_req.strb[b]) begin
                            regs_d[i][b*8 +: 8] = commit_req.wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            // NOTE: the whole register file is reset; downstream logic relies on a known zero image.
            regs_q    <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign bus.PREADY  = pready;
    assign bus.PRDATA  = prdata_q;
    assign bus.PSLVERR = pslverr_q;
    assign reg_q       = regs_q;

endmodule
